// File: rtl/uart_reg_slave.sv
// Register-bank slave behind the UART transaction master.
// RW control bank, sampled RO status slots and a fixed ID byte.
module uart_reg_slave #(
  parameter int         P_NUM_CTRL = 16,
  parameter int         P_NUM_STAT = 4,
  parameter logic [7:0] P_ID       = 8'hA5,
  parameter int         P_HOLDOFF  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              uart_MCmd,
  input  logic [7:0]              uart_MAddr,
  input  logic [7:0]              uart_MData,
  output logic                    uart_SCmdAccept,
  output logic [7:0]              uart_SData,
  output logic [1:0]              uart_SResp,
  output logic [8*P_NUM_CTRL-1:0] ctrl_regs,
  input  logic [8*P_NUM_STAT-1:0] status_in,
  output logic                    wr_pulse,
  output logic [7:0]              wr_addr
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    RESP,
    HOLD
  } state_t;

  // The IDLE cycle that samples the next command is the last holdoff cycle.
  localparam logic [7:0] HOLD_LOAD =
    8'(P_HOLDOFF > 1 ? P_HOLDOFF - 1 : 1);

  state_t     state;
  logic [2:0] cmd_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] cnt;

  logic       is_wr;
  logic       is_rd;
  logic       is_ctrl;
  logic       is_stat;
  logic       is_id;
  logic [7:0] ctrl_rd;
  logic [7:0] stat_rd;

  always_comb begin
    is_wr   = (cmd_q == 3'b001);
    is_rd   = (cmd_q == 3'b010);
    is_ctrl = ({1'b0, addr_q} < 9'(P_NUM_CTRL));
    is_stat = (addr_q >= 8'h80) &&
              ({1'b0, addr_q} < 9'(128 + P_NUM_STAT));
    is_id   = (addr_q == 8'hFF);
    ctrl_rd = 8'h00;
    stat_rd = 8'h00;
    for (int k = 0; k < P_NUM_CTRL; k++) begin
      if (addr_q == 8'(k)) ctrl_rd = ctrl_regs[8*k +: 8];
    end
    for (int k = 0; k < P_NUM_STAT; k++) begin
      if (addr_q == 8'(128 + k)) stat_rd = status_in[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cmd_q           <= 3'b000;
      addr_q          <= 8'h00;
      data_q          <= 8'h00;
      cnt             <= 8'h00;
      uart_SCmdAccept <= 1'b0;
      uart_SData      <= 8'h00;
      uart_SResp      <= 2'b00;
      ctrl_regs       <= '0;
      wr_pulse        <= 1'b0;
      wr_addr         <= 8'h00;
    end else begin
      uart_SCmdAccept <= 1'b0;
      wr_pulse        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (uart_MCmd != 3'b000) begin
            cmd_q           <= uart_MCmd;
            addr_q          <= uart_MAddr;
            data_q          <= uart_MData;
            uart_SCmdAccept <= 1'b1;
            state           <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (is_wr && is_ctrl) begin
            for (int k = 0; k < P_NUM_CTRL; k++) begin
              if (addr_q == 8'(k)) ctrl_regs[8*k +: 8] <= data_q;
            end
            wr_pulse <= 1'b1;
            wr_addr  <= addr_q;
            state    <= IDLE;
          end else if (is_rd && (is_ctrl || is_stat || is_id)) begin
            uart_SResp <= 2'b01;
            if (is_ctrl)      uart_SData <= ctrl_rd;
            else if (is_stat) uart_SData <= stat_rd;
            else              uart_SData <= P_ID;
            state <= RESP;
          end else begin
            uart_SResp <= 2'b11;
            uart_SData <= 8'h00;
            state      <= RESP;
          end
        end
        RESP: begin
          uart_SResp <= 2'b00;
          uart_SData <= 8'h00;
          if (P_HOLDOFF > 1) begin
            cnt   <= HOLD_LOAD;
            state <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_slave.sv
// Directed bench for uart_reg_slave.
// Read/error responses are scoreboarded; timing checked at each step.
module tb_uart_reg_slave;

  localparam int NC = 16;
  localparam int NS = 4;
  localparam int HO = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    uart_MCmd = 3'b000;
  logic [7:0]    uart_MAddr = 8'h00;
  logic [7:0]    uart_MData = 8'h00;
  logic          uart_SCmdAccept;
  logic [7:0]    uart_SData;
  logic [1:0]    uart_SResp;
  logic [8*NC-1:0] ctrl_regs;
  logic [8*NS-1:0] status_in = {8'h44, 8'h33, 8'h77, 8'h11};
  logic          wr_pulse;
  logic [7:0]    wr_addr;

  uart_reg_slave #(
    .P_NUM_CTRL(NC),
    .P_NUM_STAT(NS),
    .P_ID      (8'hA5),
    .P_HOLDOFF (HO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uart_MCmd      (uart_MCmd),
    .uart_MAddr     (uart_MAddr),
    .uart_MData     (uart_MData),
    .uart_SCmdAccept(uart_SCmdAccept),
    .uart_SData     (uart_SData),
    .uart_SResp     (uart_SResp),
    .ctrl_regs      (ctrl_regs),
    .status_in      (status_in),
    .wr_pulse       (wr_pulse),
    .wr_addr        (wr_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] resp;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic acc_d = 1'b0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every non-NULL response must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (acc_d) chk("accept_one_cycle", uart_SCmdAccept, 0);
      if (uart_SResp !== 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", uart_SResp, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_code", uart_SResp, mon_e.resp);
          chk("resp_data", uart_SData, mon_e.data);
        end
      end
    end
    acc_d = uart_SCmdAccept & ~reset;
  end

  task automatic issue(input logic [2:0] c, input logic [7:0] a,
                       input logic [7:0] d,
                       output int t, output int acc);
    @(posedge clk);
    #1;
    uart_MCmd  = c;
    uart_MAddr = a;
    uart_MData = d;
    t   = cyc;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (uart_SCmdAccept === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", uart_SCmdAccept, 1);
    @(posedge clk);
    #1;
    uart_MCmd = 3'b000;
  endtask

  task automatic xact(input logic [2:0] c, input logic [7:0] a,
                      input logic [7:0] d, input logic [1:0] er,
                      input logic [7:0] ed,
                      output int t, output int acc);
    if (er != 2'b00) sb.push_back('{er, ed});
    issue(c, a, d, t, acc);
    @(negedge clk);
    chk("accept_width", uart_SCmdAccept, 0);
    if (er != 2'b00) begin
      chk("resp_present", uart_SResp !== 2'b00, 1);
      chk("no_wr_pulse", wr_pulse, 0);
    end else begin
      chk("wr_pulse", wr_pulse, 1);
      chk("wr_addr", wr_addr, a);
      chk("ctrl_new_val", ctrl_regs[8*int'(a) +: 8], d);
      chk("no_resp_on_write", uart_SResp, 0);
    end
    @(negedge clk);
    chk("resp_one_cycle", uart_SResp, 0);
    chk("wr_pulse_one_cycle", wr_pulse, 0);
  endtask

  int t, a, t2, a2;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_accept", uart_SCmdAccept, 0);
    chk("rst_sresp", uart_SResp, 0);
    chk("rst_sdata", uart_SData, 0);
    chk("rst_ctrl", ctrl_regs, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_wr_addr", wr_addr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    xact(3'b001, 8'h03, 8'h5C, 2'b00, 8'h00, t, a);
    chk("wr_latency", a - t, 1);
    chk("ctrl3", ctrl_regs[31:24], 8'h5C);

    xact(3'b010, 8'h03, 8'h00, 2'b01, 8'h5C, t, a);
    chk("rd_latency", a - t, 1);
    xact(3'b010, 8'h81, 8'h00, 2'b01, 8'h77, t2, a2);
    chk("holdoff_gap", a2 - a, HO + 2);

    xact(3'b010, 8'hFF, 8'h00, 2'b01, 8'hA5, t, a);
    xact(3'b010, 8'h10, 8'h00, 2'b11, 8'h00, t, a);
    xact(3'b010, 8'h84, 8'h00, 2'b11, 8'h00, t, a);
    xact(3'b010, 8'h83, 8'h00, 2'b01, 8'h44, t, a);
    xact(3'b001, 8'h80, 8'h12, 2'b11, 8'h00, t, a);
    xact(3'b010, 8'h80, 8'h00, 2'b01, 8'h11, t, a);
    xact(3'b001, 8'h0F, 8'hFF, 2'b00, 8'h00, t, a);
    chk("ctrl15", ctrl_regs[127:120], 8'hFF);
    xact(3'b010, 8'h0F, 8'h00, 2'b01, 8'hFF, t, a);
    xact(3'b001, 8'h10, 8'h99, 2'b11, 8'h00, t, a);
    xact(3'b111, 8'h00, 8'h00, 2'b11, 8'h00, t, a);
    xact(3'b001, 8'h01, 8'h22, 2'b00, 8'h00, t, a);
    chk("ctrl_after_errs", ctrl_regs[31:0], 32'h5C00_2200);

    // Master re-presents the next read as soon as it drops the first.
    sb.push_back('{2'b01, 8'h5C});
    sb.push_back('{2'b01, 8'hA5});
    issue(3'b010, 8'h03, 8'h00, t, a);
    issue(3'b010, 8'hFF, 8'h00, t2, a2);
    chk("b2b_first_acc", a - t, 1);
    chk("b2b_second_acc", a2 - t, 3 + HO);
    repeat (3) @(negedge clk);

    @(posedge clk);
    #1;
    uart_MCmd  = 3'b010;
    uart_MAddr = 8'h03;
    a = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (uart_SCmdAccept === 1'b1) begin
        a = i;
        break;
      end
    end
    if (a < 0) chk("rst_test_accept_timeout", uart_SCmdAccept, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    uart_MCmd = 3'b000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", uart_SResp, 0);
    end
    chk("rst_ctrl_cleared", ctrl_regs, 0);
    chk("rst_wr_addr_cleared", wr_addr, 0);

    xact(3'b001, 8'h05, 8'h33, 2'b00, 8'h00, t, a);
    chk("post_rst_latency", a - t, 1);
    xact(3'b010, 8'h05, 8'h00, 2'b01, 8'h33, t, a);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
